// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-client round-robin arbiter onto a single-port memory, with
//            tagged read return. Define MEM_ARB_C0_PRIO_EN for fixed client-0
//            priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              c0_rts_in,
   output logic              c0_rtr_out,
   input  logic [ADDR_W-1:0] c0_addr,
   input  logic [DATA_W-1:0] c0_wr_data,
   input  logic [3:0]        c0_op,
   output logic [DATA_W-1:0] c0_rd_data,
   output logic              c0_rd_valid,
   input  logic              c1_rts_in,
   output logic              c1_rtr_out,
   input  logic [ADDR_W-1:0] c1_addr,
   input  logic [DATA_W-1:0] c1_wr_data,
   input  logic [3:0]        c1_op,
   output logic [DATA_W-1:0] c1_rd_data,
   output logic              c1_rd_valid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data
);

   localparam logic [3:0] c_op_read  = 4'b0001;
   localparam logic [3:0] c_op_write = 4'b0010;
   localparam logic [3:0] c_op_clear = 4'b1111;

   logic              r_last_grant;
   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_xfc0;
   logic              w_xfc1;
   logic              w_xfc;
   logic [3:0]        w_op;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wr_data;
   logic              w_is_rd;
   logic              w_is_wr;
   logic              w_access;
   // {valid, client}; stage 0 lines up with mem_en, stage RD_LAT with mem_rd_data
   logic [1:0]        r_tag [0:RD_LAT];

`ifdef MEM_ARB_C0_PRIO_EN
   always_comb begin
      w_gnt0 = c0_rts_in;
      w_gnt1 = c1_rts_in && !c0_rts_in;
   end
`else
   always_comb begin
      w_gnt0 = c0_rts_in && (!c1_rts_in || r_last_grant);
      w_gnt1 = c1_rts_in && (!c0_rts_in || !r_last_grant);
   end
`endif

   assign c0_rtr_out = w_gnt0 && rst_;
   assign c1_rtr_out = w_gnt1 && rst_;
   assign w_xfc0     = c0_rts_in && c0_rtr_out;
   assign w_xfc1     = c1_rts_in && c1_rtr_out;
   assign w_xfc      = w_xfc0 || w_xfc1;

   always_comb begin
      w_op      = w_xfc1 ? c1_op      : c0_op;
      w_addr    = w_xfc1 ? c1_addr    : c0_addr;
      w_wr_data = w_xfc1 ? c1_wr_data : c0_wr_data;
      w_is_rd   = (w_op == c_op_read);
      w_is_wr   = (w_op == c_op_write) || (w_op == c_op_clear);
      w_access  = w_xfc && (w_is_rd || w_is_wr);
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_last_grant <= 1'b1;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wr_data  <= '0;
         c0_rd_data   <= '0;
         c0_rd_valid  <= 1'b0;
         c1_rd_data   <= '0;
         c1_rd_valid  <= 1'b0;
         for (int i = 0; i <= RD_LAT; i++) begin
            r_tag[i] <= 2'b00;
         end
      end else begin
         if (w_xfc0) begin
            r_last_grant <= 1'b0;
         end else if (w_xfc1) begin
            r_last_grant <= 1'b1;
         end

         mem_en <= w_access;
         mem_we <= w_access && w_is_wr;
         if (w_access) begin
            mem_addr    <= w_addr;
            mem_wr_data <= w_wr_data;
         end

         r_tag[0] <= {w_xfc && w_is_rd, w_xfc1};
         for (int i = 1; i <= RD_LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
         end

         c0_rd_valid <= r_tag[RD_LAT][1] && !r_tag[RD_LAT][0];
         c1_rd_valid <= r_tag[RD_LAT][1] &&  r_tag[RD_LAT][0];
         if (r_tag[RD_LAT][1] && !r_tag[RD_LAT][0]) begin
            c0_rd_data <= mem_rd_data;
         end
         if (r_tag[RD_LAT][1] && r_tag[RD_LAT][0]) begin
            c1_rd_data <= mem_rd_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-client arbiter that sits directly downstream of the soft-reset memory-clear engine (client 0) and the draw/pixel engine (client 1).
- Accepts requests from both clients over rts/rtr handshakes and issues at most one access per cycle to the single-port frame/data memory (17-bit word address, 32-bit data).
- Returns read data to the client that issued the read.

Parameters:
- ADDR_W, 17, memory word-address width.
- DATA_W, 32, memory data width.
- RD_LAT, 1, memory read latency in cycles from mem_en to mem_rd_data valid (legal range 1..4).

Ports:
- clk  in  1  system clock
- rst_  in  1  asynchronous active-low reset
- c0_rts_in  in  1  client 0 request valid
- c0_rtr_out  out  1  client 0 request accepted this cycle if c0_rts_in is high
- c0_addr  in  ADDR_W  client 0 word address
- c0_wr_data  in  DATA_W  client 0 write data
- c0_op  in  4  client 0 opcode
- c0_rd_data  out  DATA_W  read data returned to client 0
- c0_rd_valid  out  1  one-cycle pulse: c0_rd_data is valid
- c1_rts_in, c1_rtr_out, c1_addr, c1_wr_data, c1_op, c1_rd_data, c1_rd_valid: identical to the c0_* ports, for client 1
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en with mem_we=0

Behaviour:
- Reset (rst_ low, asynchronous): all registered outputs go to 0 (mem_en, mem_we, mem_addr, mem_wr_data, cN_rd_data, cN_rd_valid). The read-tag pipeline is cleared. last_grant is set to 1, so client 0 wins the first tie.
- While rst_ is low, both rtr outputs are forced to 0.
- If reset asserts mid-operation, in-flight reads are dropped and no rd_valid is generated for them.
- Opcodes:
  - 4'b0001 = read.
  - 4'b0010 = write.
  - 4'b1111 = clear-write (treated as a write of cN_wr_data).
  - Any other opcode is accepted (handshake completes) but produces no memory access: mem_en stays 0 in the following cycle.
- Arbitration is combinational, evaluated every cycle:
  - Only one client has rts high: that client gets rtr.
  - Both have rts high: round-robin; the client that is not last_grant wins.
  - At most one rtr is high in any cycle; rtr is never high for a client whose rts is low.
  - The memory is always ready, so there is no back-pressure from the memory side.
- Transfer: xfc_N = cN_rts_in && cN_rtr_out. On xfc, last_grant is updated to N.
- Access timing: a transfer in cycle T drives mem_en/mem_we/mem_addr/mem_wr_data registered in cycle T+1.
  - When no transfer occurs, mem_en=0 and mem_we=0; mem_addr/mem_wr_data hold their last values.
  - Sustained throughput is one access per cycle.
- Read return:
  - Each read pushes a 2-bit tag {valid, client} into an RD_LAT-deep shift register aligned with mem_en.
  - When the tag emerges (cycle T+1+RD_LAT), mem_rd_data is registered into the tagged client's rd_data, and that client's rd_valid pulses at T+2+RD_LAT.
  - With RD_LAT=1: accept at T, rd_valid at T+3.
  - The other client's rd_data holds its previous value.
  - Clients must sink rd_valid unconditionally; there is no return back-pressure.
- Back-to-back reads from alternating clients return in issue order, each tagged correctly. Reads and writes to the same address are not reordered: the memory sees them in grant order.

Optional Feature:
- Macro MEM_ARB_C0_PRIO_EN.
- Defined: fixed priority. Client 0 wins whenever c0_rts_in is high, so a soft-reset clear sweep completes without interleaving, and client 1 may starve. last_grant is still updated but unused.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then c0 only: write op 4'b0010, addr 0x00005, data 0xDEADBEEF at T -> c0_rtr_out=1 at T; mem_en=1, mem_we=1, mem_addr=0x00005, mem_wr_data=0xDEADBEEF at T+1.
- Both rts held high with writes for 4 cycles after reset -> grants alternate 0,1,0,1 and mem_en is high on 4 consecutive cycles. With MEM_ARB_C0_PRIO_EN defined -> grants 0,0,0,0.
- c0 reads 0x1FFFF at T, c1 reads 0x00000 at T+1, memory model returns 0xA5A5A5A5 then 0x5A5A5A5A (RD_LAT=1) -> c0_rd_valid at T+3 with 0xA5A5A5A5; c1_rd_valid at T+4 with 0x5A5A5A5A; c0_rd_data unchanged at T+4.
- c1 op 4'b0111 -> c1_rtr_out=1, mem_en=0 next cycle, no rd_valid.
- Issue a c0 read, then pull rst_ low before the return -> all outputs 0 immediately; no rd_valid after reset releases.
- Clear sweep: 131072 consecutive c0 op 4'b1111 writes, addresses 0..0x1FFFF, with c1 idle -> 131072 mem_en pulses with mem_we=1 and mem_wr_data=0.
